fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
Read-side controller for the loop-back FIFO memory. It owns the read pointer and drives the memory read port (enable and address). It returns read data to a downstream consumer over a valid/ready stream at one word per cycle. It also hands its read pointer back to the write side for full detection. Single clock domain; write side and memory share `clk_r`.

Parameters:
- DW, 33, data word width (matches memory word)
- AW, 5, memory address width; depth = 2^AW = 32 entries
- OBUF, 2, output buffer depth (fixed at 2; guarantees full throughput with 1-cycle memory latency)

Ports:
- clk_r  input  1  read clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- wr_ptr  input  AW+1  write pointer from write side, binary with wrap bit, same clock
- rd_ptr  output  AW+1  read pointer (next entry to issue), binary with wrap bit
- mem_re  output  1  memory read enable
- mem_raddr  output  AW  memory read address = rd_ptr[AW-1:0]
- mem_rdata  input  DW  memory read data, valid the cycle after mem_re
- out_valid  output  1  output word available
- out_ready  input  1  consumer accepts word
- out_data  output  DW  output word
- level  output  AW+1  words held (unissued + in flight + buffered)
- flush  input  1  present only with RD_FLUSH_EN

Behaviour:
- Reset (async assert, sync release): rd_ptr=0, mem_re=0, out_valid=0, out_data=0, level=0, output buffer empty, in-flight flag cleared.
- empty = (wr_ptr == rd_ptr). The gap wr_ptr-rd_ptr (mod 2^(AW+1)) never exceeds 2^AW; a gap above that is a protocol error flagged by an assertion.
- pop = out_valid && out_ready. A pop consumes the oldest buffered word.
- slots = buf_cnt + inflight, where inflight is 1 if mem_re was high in the previous cycle.
- Issue rule: mem_re = !empty && (slots < 2 || (slots == 2 && pop)). Evaluated combinationally.
- On issue, rd_ptr <= rd_ptr+1, wrapping naturally in AW+1 bits (31→32 flips the wrap bit; 63→0).
- Data return: in the cycle after issue, mem_rdata is written into the output buffer at the clock edge.
- Latency: a word issued in cycle t is on out_data with out_valid=1 in cycle t+2.
  - If wr_ptr advances in cycle t-1, first out_valid is in cycle t+2.
- Throughput: 1 word/cycle sustained while out_ready=1 and not empty.
- Stream rules:
  - out_data and out_valid hold stable while out_valid && !out_ready.
  - Words are delivered in address order with no loss or duplication.
- Simultaneous pop and data return with buffer full: the pop frees the head and the returned word enters the tail in the same edge.
- level = (wr_ptr - rd_ptr) + inflight + buf_cnt, registered, updated every cycle.
- Reset mid-operation: the in-flight read is discarded and the buffer is cleared; the write side must also reset.

Optional Feature:
Macro RD_FLUSH_EN.
- With the macro: a `flush` port is added. When flush=1 at an edge:
  - rd_ptr <= wr_ptr, buffer cleared, in-flight return discarded.
  - out_valid=0 and mem_re=0 in that cycle.
  - flush has priority over issue, pop and data return.
  - Normal operation resumes the cycle after flush deasserts.
- Without the macro: no `flush` port and no flush logic.

Decomposition:
- Package `fifo_pkg`: DW and AW defaults, a pointer typedef (AW+1 bits), and a word typedef (DW bits). The write side shares this package.
- One sub-module, `rd_skid_buf`: the 2-entry output buffer with count, push (data return), and pop/valid/ready.
- The top level holds the pointer, issue logic and level.

Test Plan:
- Reset, then write 1 word (wr_ptr 0→1), out_ready=1 → mem_re in the next cycle with mem_raddr=0; out_valid 2 cycles later with data=mem[0]; level returns to 0.
- Burst of 32 words, out_ready=1 → 32 consecutive out_valid cycles, in-order data, rd_ptr ends at 32 (wrap bit set).
- Burst with out_ready held 0 → mem_re stops after 2 issues; out_data stable; level=32. Then ready=1 → all 32 drain, no loss.
- Pointer wrap: prefill so rd_ptr=62, write 4 words → addresses 30,31,0,1 are issued; rd_ptr wraps 63→0.
- out_ready toggling every cycle with a random stream → scoreboard confirms order, no duplicates, stability under stall.
- RD_FLUSH_EN: flush with 10 pending and 2 buffered → next cycle out_valid=0, level=0, rd_ptr==wr_ptr, and no stale word appears afterward.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pkg
// Purpose : Shared definitions for the loop-back FIFO (read and write sides).
//           Default data/address widths, pointer and word types, and a
//           pointer-distance helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int FIFO_DW = 33;  // memory word width
  localparam int FIFO_AW = 5;   // memory address width, depth = 2**FIFO_AW

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [FIFO_AW:0]   ptr_t;
  typedef logic [FIFO_DW-1:0] word_t;

  // Words between two pointers; modulo arithmetic handles the wrap bit.
  function automatic ptr_t ptr_gap(input ptr_t wr, input ptr_t rd);
    return wr - rd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : fifo_rd_ctrl_if
// Purpose : Bundles the memory read port and the downstream valid/ready
//           stream of the FIFO read controller.
// Ports   : mem_re, mem_raddr, mem_rdata  - memory read port
//           out_valid, out_ready, out_data - output stream
// Modports: master - read controller side
//           slave  - memory + consumer side
// Revision: 1.0 - initial release
// ============================================================================
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DW = FIFO_DW,
  parameter int AW = FIFO_AW
);

  logic          mem_re;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output mem_re, mem_raddr, out_valid, out_data,
    input  mem_rdata, out_ready
  );

  modport slave (
    input  mem_re, mem_raddr, out_valid, out_data,
    output mem_rdata, out_ready
  );

endinterface
`default_nettype wire

// File: rtl/rd_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : rd_skid_buf
// Purpose : Two-entry in-order output buffer between the memory read port and
//           the valid/ready consumer. Entry 0 (head) always drives data, so
//           data stays stable while the consumer stalls.
// Ports   : clk, rst_n     - clock, async active-low reset
//           clear          - drop all buffered words
//           push/push_data - returned memory word
//           pop            - consumer took the head (only when valid)
//           valid/data     - head word
//           count          - words held (0..2)
// Revision: 1.0 - initial release
// ============================================================================
module rd_skid_buf #(
  parameter int DW = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [1:0]    count
);

  logic [DW-1:0] r_head;
  logic [DW-1:0] r_tail;
  logic [1:0]    r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else if (clear) begin
      r_cnt  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= push_data;
          else               r_tail <= push_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Head leaves and the new word enters the tail on the same edge.
          if (r_cnt == 2'd1) begin
            r_head <= push_data;
          end else begin
            r_head <= r_tail;
            r_tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (r_cnt != 2'd0);
  assign data  = r_head;
  assign count = r_cnt;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fifo_rd_ctrl
// Purpose : Read-side controller of the loop-back FIFO. Owns the read
//           pointer, issues memory reads (1-cycle latency) and streams words
//           to the consumer at one word per cycle through a 2-entry buffer.
// Ports   : clk_r  - clock            rst_n  - async active-low reset
//           wr_ptr - write pointer     rd_ptr - read pointer (to write side)
//           level  - words held (unissued + in flight + buffered)
//           flush  - drop everything (only with RD_FLUSH_EN)
//           bus    - memory read port + output stream (master modport)
// Config  : `define RD_FLUSH_EN adds the flush port and logic.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DW   = FIFO_DW,
  parameter int AW   = FIFO_AW,
  parameter int OBUF = 2
) (
  input  logic          clk_r,
  input  logic          rst_n,
`ifdef RD_FLUSH_EN
  input  logic          flush,
`endif
  input  logic [AW:0]   wr_ptr,
  output logic [AW:0]   rd_ptr,
  output logic [AW:0]   level,
  fifo_rd_ctrl_if.master bus
);

  localparam logic [2:0] C_OBUF = 3'(OBUF);

  logic          w_flush;
  logic [AW:0]   w_gap;
  logic          w_empty;
  logic          w_pop;
  logic          w_issue;
  logic          w_buf_valid;
  logic [DW-1:0] w_buf_data;
  logic [1:0]    w_buf_cnt;
  logic [2:0]    w_slots;
  logic [AW:0]   w_level_now;
  logic          r_inflight;
  logic [AW:0]   r_rd_ptr;
  logic [AW:0]   r_level;

`ifdef RD_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_gap   = wr_ptr - r_rd_ptr;
  assign w_empty = (w_gap == '0);

  // Buffer slots already spoken for: words held plus the one returning now.
  assign w_slots = {1'b0, w_buf_cnt} + {2'b00, r_inflight};

  assign bus.out_valid = w_buf_valid && !w_flush;
  assign bus.out_data  = w_buf_data;
  assign w_pop         = bus.out_valid && bus.out_ready;

  // A read may be issued when its word is guaranteed a buffer slot on return;
  // a pop this cycle frees one slot in time.
  assign w_issue = !w_flush && !w_empty &&
                   ((w_slots < C_OBUF) || ((w_slots == C_OBUF) && w_pop));

  assign bus.mem_re    = w_issue;
  assign bus.mem_raddr = r_rd_ptr[AW-1:0];

  assign w_level_now = w_gap + {{AW{1'b0}}, r_inflight}
                             + {{(AW-1){1'b0}}, w_buf_cnt};

  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
      r_level    <= '0;
    end else if (w_flush) begin
      r_rd_ptr   <= wr_ptr;
      r_inflight <= 1'b0;
      r_level    <= '0;
    end else begin
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_inflight <= w_issue;
      r_level    <= w_level_now;
    end
  end

  rd_skid_buf #(
    .DW (DW)
  ) u_skid (
    .clk       (clk_r),
    .rst_n     (rst_n),
    .clear     (w_flush),
    .push      (r_inflight),
    .push_data (bus.mem_rdata),
    .pop       (w_pop),
    .valid     (w_buf_valid),
    .data      (w_buf_data),
    .count     (w_buf_cnt)
  );

  assign rd_ptr = r_rd_ptr;
  assign level  = r_level;

  // The write side must never run more than one full memory ahead.
  a_gap_bound : assert property (@(posedge clk_r) disable iff (!rst_n)
                                 !(w_gap[AW] && (|w_gap[AW-1:0])));

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_rd_ctrl
// Purpose : Self-checking bench for fifo_rd_ctrl. Stimulus pushes expected
//           words into a queue; a monitor pops and compares on every
//           accepted output word and checks stream stability under stall.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;

  localparam int DW = FIFO_DW;
  localparam int AW = FIFO_AW;

  logic  clk_r = 1'b0;
  logic  rst_n = 1'b0;
  logic  flush = 1'b0;
  ptr_t  wr_ptr = '0;
  ptr_t  rd_ptr;
  ptr_t  level;

  fifo_rd_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  fifo_rd_ctrl #(.DW(DW), .AW(AW), .OBUF(2)) dut (
    .clk_r  (clk_r),
    .rst_n  (rst_n),
`ifdef RD_FLUSH_EN
    .flush  (flush),
`endif
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .level  (level),
    .bus    (bus)
  );

  always #5 clk_r = ~clk_r;

  word_t     mem [0:(1<<AW)-1];
  word_t     exp_q[$];
  int        addr_q[$];
  int        vectors = 0;
  int        miscompares = 0;
  int        cyc = 0;
  int        pop_cnt = 0;
  int        first_pop = -1;
  int        last_pop = -1;
  int        seq = 0;
  logic      held = 1'b0;
  word_t     held_data = '0;

  initial bus.out_ready = 1'b0;
  initial bus.mem_rdata = '0;

  always @(posedge clk_r) cyc <= cyc + 1;

  // Memory model: one-cycle read latency.
  always @(posedge clk_r) if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_raddr];

  // Log of issued read addresses.
  always @(negedge clk_r) if (rst_n && bus.mem_re) addr_q.push_back(int'(bus.mem_raddr));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk_r) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held && !flush) begin
        vectors++;
        if (!(bus.out_valid && bus.out_data == held_data)) begin
          miscompares++;
          $display("FAIL stall_stable: got valid=%0b data=%0h, expected valid=1 data=%0h",
                   bus.out_valid, bus.out_data, held_data);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL out_data: got unexpected word %0h, expected none", bus.out_data);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin
            miscompares++;
            $display("FAIL out_data: got %0h, expected %0h", bus.out_data, e);
          end
        end
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      held      = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
    end
  end

  task automatic tick();
    @(posedge clk_r);
    #1;
  endtask

  function automatic word_t next_word();
    word_t w;
    w = {1'b1, 16'hC0DE, seq[15:0]};
    seq++;
    return w;
  endfunction

  // Write n words in one edge (caller keeps the gap within depth).
  task automatic push_words(input int n, input logic rnd);
    for (int i = 0; i < n; i++) begin
      word_t      w;
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      w = rnd ? r[DW-1:0] : next_word();
      mem[wr_ptr[AW-1:0]] = w;
      exp_q.push_back(w);
      wr_ptr = wr_ptr + 1'b1;
    end
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    wr_ptr = '0;
    bus.out_ready = 1'b0;
    flush = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    pop_cnt = 0;
    first_pop = -1;
    last_pop = -1;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    tick();
    rst_n = 1'b0;
    @(negedge clk_r);
    check("rst_rd_ptr", 64'(rd_ptr), 64'd0);
    check("rst_mem_re", 64'(bus.mem_re), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_level", 64'(level), 64'd0);

    // Single word
    do_reset();
    bus.out_ready = 1'b1;
    tick();
    push_words(1, 1'b0);
    @(negedge clk_r);
    check("single_mem_re", 64'(bus.mem_re), 64'd1);
    check("single_raddr", 64'(bus.mem_raddr), 64'd0);
    tick();
    @(negedge clk_r);
    check("single_valid_t1", 64'(bus.out_valid), 64'd0);
    tick();
    @(negedge clk_r);
    check("single_valid_t2", 64'(bus.out_valid), 64'd1);
    drain("single_drain", 20);
    repeat (3) tick();
    @(negedge clk_r);
    check("single_level", 64'(level), 64'd0);

    // Full-depth burst at full throughput
    do_reset();
    bus.out_ready = 1'b1;
    tick();
    push_words(32, 1'b0);
    drain("burst_drain", 60);
    check("burst_pops", 64'(pop_cnt), 64'd32);
    check("burst_consecutive", 64'(last_pop - first_pop), 64'd31);
    check("burst_rd_ptr", 64'(rd_ptr), 64'd32);

    // Burst against a stalled consumer
    do_reset();
    tick();
    push_words(32, 1'b0);
    repeat (8) tick();
    @(negedge clk_r);
    check("stall_rd_ptr", 64'(rd_ptr), 64'd2);
    check("stall_mem_re", 64'(bus.mem_re), 64'd0);
    check("stall_level", 64'(level), 64'd32);
    check("stall_valid", 64'(bus.out_valid), 64'd1);
    check("stall_head", 64'(bus.out_data), 64'(exp_q[0]));
    tick();
    bus.out_ready = 1'b1;
    drain("stall_drain", 60);

    // Pointer wrap
    do_reset();
    bus.out_ready = 1'b1;
    tick();
    push_words(31, 1'b0);
    drain("wrap_pre1", 60);
    push_words(31, 1'b0);
    drain("wrap_pre2", 60);
    repeat (2) tick();
    check("wrap_rd_ptr62", 64'(rd_ptr), 64'd62);
    addr_q.delete();
    push_words(4, 1'b0);
    drain("wrap_drain", 30);
    check("wrap_n_issued", 64'(addr_q.size()), 64'd4);
    if (addr_q.size() == 4) begin
      check("wrap_addr0", 64'(addr_q[0]), 64'd30);
      check("wrap_addr1", 64'(addr_q[1]), 64'd31);
      check("wrap_addr2", 64'(addr_q[2]), 64'd0);
      check("wrap_addr3", 64'(addr_q[3]), 64'd1);
    end
    check("wrap_rd_ptr", 64'(rd_ptr), 64'd2);

    // Random stream with ready toggling every cycle
    do_reset();
    tick();
    for (int n = 0; n < 100; ) begin
      bus.out_ready = ~bus.out_ready;
      if (ptr_gap(wr_ptr, rd_ptr) < 6'd32 && $urandom_range(0, 3) != 0) begin
        push_words(1, 1'b1);
        n++;
      end
      tick();
    end
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
      bus.out_ready = ~bus.out_ready;
      tick();
    end
    check("toggle_left", 64'(exp_q.size()), 64'd0);
    check("toggle_pops", 64'(pop_cnt), 64'd100);

`ifdef RD_FLUSH_EN
    // Flush with 10 pending and 2 buffered
    do_reset();
    tick();
    push_words(12, 1'b0);
    repeat (8) tick();
    flush = 1'b1;
    @(negedge clk_r);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_mem_re", 64'(bus.mem_re), 64'd0);
    tick();
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk_r);
    check("flush_level", 64'(level), 64'd0);
    check("flush_ptrs", 64'(rd_ptr), 64'(wr_ptr));
    check("flush_valid_after", 64'(bus.out_valid), 64'd0);
    tick();
    bus.out_ready = 1'b1;
    push_words(3, 1'b0);
    drain("flush_resume", 30);
    repeat (4) tick();
    check("flush_no_stale", 64'(exp_q.size()), 64'd0);
`endif

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
